// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the IReq/IAck handshake and feeds decode
// through an output register backed by a one-entry skid buffer, with delay-slot-aware redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        RedirValid,
  input  logic [31:0] RedirPC,
  input  logic        Flush,
  input  logic [31:0] FlushPC,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IRdata,
  output logic        IRValid,
  output logic [31:0] IR,
  output logic [31:0] IRPC,
  output logic [31:0] IRNPC
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] irpc_q, irpc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        kill_q, kill_d;

  logic        busy;
  logic        ack;
  logic        consume;
  logic        redir;
  logic        slot_unreq;
  logic        pend_now;
  logic [31:0] pend_tgt_now;
  logic        word_ok;
  logic [31:0] redir_aligned;
  logic [31:0] flush_aligned;

  assign busy          = (state_q == StBusy);
  assign ack           = busy && IAck;
  assign consume       = ir_valid_q && !Stall;
  assign redir         = consume && RedirValid && !Flush;
  // PC still equals the delay-slot address: the slot has not been acked yet.
  assign slot_unreq    = (pc_q == (irpc_q + 32'd4));
  assign redir_aligned = {RedirPC[31:2], 2'b00};
  assign flush_aligned = {FlushPC[31:2], 2'b00};
  assign pend_now      = pend_q || (redir && slot_unreq);
  assign pend_tgt_now  = (redir && slot_unreq) ? redir_aligned : pend_tgt_q;
  assign word_ok       = ack && !kill_q && !Flush;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    iaddr_d      = iaddr_q;
    ir_valid_d   = ir_valid_q;
    ir_d         = ir_q;
    irpc_d       = irpc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    kill_d       = kill_q;

    // Output register and skid routing.
    if (consume) begin
      if (skid_valid_q) begin
        ir_d         = skid_data_q;
        irpc_d       = skid_pc_q;
        skid_valid_d = 1'b0;
        if (word_ok) begin
          skid_data_d  = IRdata;
          skid_pc_d    = iaddr_q;
          skid_valid_d = 1'b1;
        end
      end else if (word_ok) begin
        ir_d   = IRdata;
        irpc_d = iaddr_q;
      end else begin
        ir_valid_d = 1'b0;
      end
    end else if (word_ok) begin
      if (!ir_valid_q) begin
        ir_d       = IRdata;
        irpc_d     = iaddr_q;
        ir_valid_d = 1'b1;
      end else begin
        skid_data_d  = IRdata;
        skid_pc_d    = iaddr_q;
        skid_valid_d = 1'b1;
      end
    end

    // PC advance, pending-redirect resolution and killed-word disposal.
    if (ack) begin
      if (kill_q) begin
        kill_d = 1'b0;
      end else begin
        pc_d   = pend_now ? pend_tgt_now : (pc_q + 32'd4);
        pend_d = 1'b0;
      end
    end else if (redir && slot_unreq) begin
      pend_d     = 1'b1;
      pend_tgt_d = redir_aligned;
    end
    if (redir && !slot_unreq) begin
      pc_d = redir_aligned;
    end

    if (Flush) begin
      ir_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      pend_d       = 1'b0;
      pc_d         = flush_aligned;
      // An outstanding request cannot be withdrawn, so its word must be dropped on arrival.
      kill_d       = busy && !IAck;
    end

    // Issue a new request whenever nothing is outstanding and the skid will be empty.
    if (!busy || ack) begin
      if (!skid_valid_d) begin
        state_d = StBusy;
        iaddr_d = pc_d;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      iaddr_q      <= RESET_PC;
      ir_valid_q   <= 1'b0;
      ir_q         <= '0;
      irpc_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      iaddr_q      <= iaddr_d;
      ir_valid_q   <= ir_valid_d;
      ir_q         <= ir_d;
      irpc_q       <= irpc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      kill_q       <= kill_d;
    end
  end

  assign IReq    = busy;
  assign IAddr   = iaddr_q;
  assign IRValid = ir_valid_q;
  assign IR      = ir_q;
  assign IRPC    = irpc_q;
  assign IRNPC   = irpc_q + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: latency-configurable memory model, a scoreboard of expected
// delivered PCs popped on every consumption, and per-step checks of the request stream.
module tb_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Stall = 1'b0;
  logic        RedirValid = 1'b0;
  logic [31:0] RedirPC = '0;
  logic        Flush = 1'b0;
  logic [31:0] FlushPC = '0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic [31:0] IRdata;
  logic        IRValid;
  logic [31:0] IR;
  logic [31:0] IRPC;
  logic [31:0] IRNPC;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat = 0;
  int wcnt = 0;
  bit mem_hold = 1'b0;
  logic        found;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .RedirValid(RedirValid), .RedirPC(RedirPC),
    .Flush(Flush), .FlushPC(FlushPC), .IReq(IReq), .IAddr(IAddr), .IAck(IAck),
    .IRdata(IRdata), .IRValid(IRValid), .IR(IR), .IRPC(IRPC), .IRNPC(IRNPC)
  );

  always #5 Clk = ~Clk;

  // Memory: acks after 'lat' wait cycles; data word is the inverted address.
  assign IAck   = IReq && !mem_hold && (wcnt >= lat);
  assign IRdata = ~IAddr;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) wcnt <= 0;
    else if (IReq && !IAck) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard pop on consumption; accepted-request log.
  always @(negedge Clk) begin
    if (Rst_n && IReq && IAck) acc_q.push_back(IAddr);
    if (Rst_n && IRValid && !Stall && !Flush) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_irpc", IRPC, e);
        chk("sb_ir", IR, ~e);
        chk("sb_irnpc", IRNPC, e + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Stall = 1'b0;
    RedirValid = 1'b0;
    Flush = 1'b0;
    mem_hold = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
    Stall = 1'b1;
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic [31:0] expv);
    if (acc_q.size() > idx) chk(tag, acc_q[idx], expv);
    else chk({tag, "_size"}, 32'(acc_q.size()), 32'(idx + 1));
  endtask

  task automatic find_irpc(input logic [31:0] pc, input string tag);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (IRValid && IRPC == pc) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset values, zero-wait streaming.
    lat = 0;
    do_reset();
    chk("rst_ireq", 32'(IReq), 32'd0);
    chk("rst_iaddr", IAddr, 32'h3000);
    chk("rst_irvalid", 32'(IRValid), 32'd0);
    chk("rst_irnpc", IRNPC, 32'h4);
    push_seq(32'h3000, 8);
    tick();
    chk("t1_first_ireq", 32'(IReq), 32'd1);
    chk("t1_first_iaddr", IAddr, 32'h3000);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t1_iaddr", IAddr, 32'h3000 + 32'(4 * k));
      chk("t1_irpc", IRPC, 32'h3000 + 32'(4 * (k - 1)));
      chk("t1_irvalid", 32'(IRValid), 32'd1);
    end
    drain("t1_drain");
    for (int i = 0; i < 8; i++) chk_acc("t1_acc", i, 32'h3000 + 32'(4 * i));

    // Test 2: three-cycle stall fills the skid and drops IReq.
    do_reset();
    push_seq(32'h3000, 5);
    repeat (3) tick();
    chk("t2_pre_irpc", IRPC, 32'h3004);
    Stall = 1'b1;
    tick();
    chk("t2_ireq_drop", 32'(IReq), 32'd0);
    chk("t2_hold_irpc", IRPC, 32'h3004);
    repeat (2) begin
      tick();
      chk("t2_ireq_low", 32'(IReq), 32'd0);
    end
    Stall = 1'b0;
    tick();
    chk("t2_rel_irpc", IRPC, 32'h3008);
    chk("t2_rel_iaddr", IAddr, 32'h300C);
    chk("t2_rel_ireq", 32'(IReq), 32'd1);
    tick();
    chk("t2_next_irpc", IRPC, 32'h300C);
    drain("t2_drain");
    for (int i = 0; i < 5; i++) chk_acc("t2_acc", i, 32'h3000 + 32'(4 * i));

    // Test 3: branch at 0x3010, zero-wait memory.
    do_reset();
    push_seq(32'h3000, 6);
    push_seq(32'h3100, 2);
    find_irpc(32'h3010, "t3_find");
    chk("t3_slot_iaddr", IAddr, 32'h3014);
    RedirValid = 1'b1;
    RedirPC = 32'h3100;
    tick();
    RedirValid = 1'b0;
    chk("t3_tgt_iaddr", IAddr, 32'h3100);
    chk("t3_slot_irpc", IRPC, 32'h3014);
    drain("t3_drain");
    chk_acc("t3_acc_slot", 5, 32'h3014);
    chk_acc("t3_acc_tgt", 6, 32'h3100);

    // Test 4: same branch with slow memory; redirect is held pending behind the slot.
    lat = 2;
    do_reset();
    push_seq(32'h3000, 6);
    push_seq(32'h3100, 1);
    find_irpc(32'h3010, "t4_find");
    chk("t4_slot_iaddr", IAddr, 32'h3014);
    RedirValid = 1'b1;
    RedirPC = 32'h3100;
    tick();
    RedirValid = 1'b0;
    for (int i = 0; i < 10 && IAddr == 32'h3014; i++) tick();
    chk("t4_tgt_iaddr", IAddr, 32'h3100);
    drain("t4_drain");
    chk_acc("t4_acc_slot", 5, 32'h3014);
    chk_acc("t4_acc_tgt", 6, 32'h3100);

    // Test 5: flush while 0x3020 is outstanding; its late ack is dropped.
    lat = 0;
    do_reset();
    push_seq(32'h3000, 8);
    for (int i = 0; i < 30 && IAddr != 32'h3020; i++) tick();
    mem_hold = 1'b1;
    chk("t5_out_iaddr", IAddr, 32'h3020);
    tick();
    chk("t5_pre_irvalid", 32'(IRValid), 32'd0);
    chk("t5_pre_sb", 32'(exp_q.size()), 32'd0);
    Flush = 1'b1;
    FlushPC = 32'h0180;
    push_seq(32'h0180, 3);
    tick();
    Flush = 1'b0;
    chk("t5_fl_irvalid", 32'(IRValid), 32'd0);
    chk("t5_fl_ireq", 32'(IReq), 32'd1);
    chk("t5_fl_iaddr", IAddr, 32'h3020);
    tick();
    chk("t5_wait_iaddr", IAddr, 32'h3020);
    mem_hold = 1'b0;
    tick();
    chk("t5_drop_irvalid", 32'(IRValid), 32'd0);
    chk("t5_new_iaddr", IAddr, 32'h0180);
    tick();
    chk("t5_new_irpc", IRPC, 32'h0180);
    drain("t5_drain");

    // Test 6: asynchronous reset during BUSY.
    do_reset();
    push_seq(32'h3000, 1);
    repeat (2) tick();
    mem_hold = 1'b1;
    tick();
    chk("t6_pre_ireq", 32'(IReq), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t6_ireq", 32'(IReq), 32'd0);
    chk("t6_iaddr", IAddr, 32'h3000);
    chk("t6_irvalid", 32'(IRValid), 32'd0);
    chk("t6_ir", IR, 32'h0);
    chk("t6_irpc", IRPC, 32'h0);
    chk("t6_irnpc", IRNPC, 32'h4);
    mem_hold = 1'b0;
    exp_q.delete();
    acc_q.delete();
    push_seq(32'h3000, 4);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    chk("t6_restart_ireq", 32'(IReq), 32'd1);
    chk("t6_restart_iaddr", IAddr, 32'h3000);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
